// File: rtl/coin_accumulator.sv
// Coin-intake controller: synchronises the coin/cancel buttons, accumulates credit in
// multiples of 100, vends once PRICE is reached and returns change or refunds on cancel.
module coin_accumulator #(
   parameter int unsigned PRICE      = 1000,
   parameter int unsigned MAX_AMOUNT = 1500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        coin100,
   input  logic        coin500,
   input  logic        cancel,
   output logic [11:0] cantidad,
   output logic        dispense,
   output logic        change_valid,
   output logic [11:0] change,
   output logic        reject,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

   localparam logic [12:0] PRICE_W = 13'(PRICE);
   localparam logic [12:0] MAX_W   = 13'(MAX_AMOUNT);
   localparam logic [12:0] VAL_100 = 13'd100;
   localparam logic [12:0] VAL_500 = 13'd500;

   logic [2:0]  raw;
   logic [2:0]  sync1_q, sync2_q, prev_q;
   logic [2:0]  evt;
   logic        evt_100, evt_500, evt_cancel, evt_coin, evt_both;
   logic [12:0] coin_val;
   logic [12:0] sum;
   logic        credit_full;

   state_t      state_q, state_d;
   logic [11:0] cantidad_q, cantidad_d;
   logic [11:0] change_q, change_d;
   logic        dispense_q, dispense_d;
   logic        change_valid_q, change_valid_d;
   logic        reject_q, reject_d;
   logic        busy_q, busy_d;

   assign raw = {cancel, coin500, coin100};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // One event per press: synchronised level rising against its previous sample.
   assign evt        = sync2_q & ~prev_q;
   assign evt_100    = evt[0];
   assign evt_500    = evt[1];
   assign evt_cancel = evt[2];
   assign evt_coin   = evt_100 | evt_500;
   assign evt_both   = evt_100 & evt_500;

   assign coin_val    = evt_500 ? VAL_500 : VAL_100;
   assign sum         = {1'b0, cantidad_q} + coin_val;
   assign credit_full = ({1'b0, cantidad_q} >= PRICE_W);

   always_comb begin
      state_d        = state_q;
      cantidad_d     = cantidad_q;
      change_d       = '0;
      dispense_d     = 1'b0;
      change_valid_d = 1'b0;
      reject_d       = 1'b0;
      busy_d         = 1'b0;

      case (state_q)
         IDLE: begin
            cantidad_d = '0;
            if (evt_coin) begin
               if (coin_val <= MAX_W) begin
                  cantidad_d = coin_val[11:0];
                  state_d    = COLLECT;
               end else begin
                  reject_d = 1'b1;
               end
               if (evt_both) begin
                  reject_d = 1'b1;
               end
            end
         end

         COLLECT: begin
            // Credit at or above the price commits to a vend; nothing else is taken that cycle.
            if (credit_full) begin
               state_d        = VEND;
               dispense_d     = 1'b1;
               change_valid_d = 1'b1;
               change_d       = cantidad_q - PRICE_W[11:0];
               busy_d         = 1'b1;
               reject_d       = evt_coin;
            end else if (evt_cancel) begin
               state_d        = REFUND;
               change_valid_d = 1'b1;
               change_d       = cantidad_q;
               busy_d         = 1'b1;
               reject_d       = evt_coin;
            end else if (evt_coin) begin
               if (sum <= MAX_W) begin
                  cantidad_d = sum[11:0];
               end else begin
                  reject_d = 1'b1;
               end
               if (evt_both) begin
                  reject_d = 1'b1;
               end
            end
         end

         VEND, REFUND: begin
            state_d    = IDLE;
            cantidad_d = '0;
            reject_d   = evt_coin;
         end

         default: begin
            state_d    = IDLE;
            cantidad_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cantidad_q     <= '0;
         change_q       <= '0;
         dispense_q     <= 1'b0;
         change_valid_q <= 1'b0;
         reject_q       <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cantidad_q     <= cantidad_d;
         change_q       <= change_d;
         dispense_q     <= dispense_d;
         change_valid_q <= change_valid_d;
         reject_q       <= reject_d;
         busy_q         <= busy_d;
      end
   end

   assign cantidad     = cantidad_q;
   assign change       = change_q;
   assign dispense     = dispense_q;
   assign change_valid = change_valid_q;
   assign reject       = reject_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: two instances (PRICE 1000 and 1500) share the buttons and are
// checked every cycle against a credit-level model, plus per-step totals from a vector table.
module tb_coin_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        coin100 = 1'b0;
   logic        coin500 = 1'b0;
   logic        cancel = 1'b0;

   logic [11:0] cant_a, chg_a, cant_b, chg_b;
   logic        disp_a, cv_a, rej_a, busy_a;
   logic        disp_b, cv_b, rej_b, busy_b;

   int checks = 0;
   int errors = 0;

   coin_accumulator #(.PRICE(1000), .MAX_AMOUNT(1500)) dut_a (
      .clk(clk), .rst_n(rst_n), .coin100(coin100), .coin500(coin500), .cancel(cancel),
      .cantidad(cant_a), .dispense(disp_a), .change_valid(cv_a), .change(chg_a),
      .reject(rej_a), .busy(busy_a)
   );

   coin_accumulator #(.PRICE(1500), .MAX_AMOUNT(1500)) dut_b (
      .clk(clk), .rst_n(rst_n), .coin100(coin100), .coin500(coin500), .cancel(cancel),
      .cantidad(cant_b), .dispense(disp_b), .change_valid(cv_b), .change(chg_b),
      .reject(rej_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   // Reference model: credit plus a phase (0 collecting/idle, 1 price reached, 2 paying out).
   int          price_m [2] = '{1000, 1500};
   int          credit_m[2];
   int          phase_m [2];
   int          mcant   [2];
   int          mchg    [2];
   bit          mdisp   [2];
   bit          mcv     [2];
   bit          mrej    [2];
   bit          mbusy   [2];
   logic [2:0]  seen1, seen2, seen3;

   int          acc_disp[2];
   int          acc_cv  [2];
   int          acc_chg [2];
   int          acc_rej [2];

   typedef struct {
      logic [2:0] btn;
      int hold;
      int gap;
      bit chk;
      int ca, da, va, ga, ra;
      int cb, db, vb, gb, rb;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      seen1 = '0;
      seen2 = '0;
      seen3 = '0;
      for (int p = 0; p < 2; p++) begin
         credit_m[p] = 0; phase_m[p] = 0; mcant[p] = 0; mchg[p] = 0;
         mdisp[p] = 0; mcv[p] = 0; mrej[p] = 0; mbusy[p] = 0;
      end
   endtask

   task automatic model_step(input logic [2:0] raw);
      logic [2:0] ev;
      bit         c100, c500, ccan, coins;
      int         v;
      // A press is seen once: high two edges ago, low three edges ago.
      ev    = seen2 & ~seen3;
      seen3 = seen2;
      seen2 = seen1;
      seen1 = raw;
      c100  = ev[0];
      c500  = ev[1];
      ccan  = ev[2];
      coins = c100 | c500;
      for (int p = 0; p < 2; p++) begin
         mdisp[p] = 0; mcv[p] = 0; mchg[p] = 0; mrej[p] = 0; mbusy[p] = 0;
         if (phase_m[p] == 2) begin
            credit_m[p] = 0;
            phase_m[p]  = 0;
            mrej[p]     = coins;
         end else if (phase_m[p] == 1) begin
            mdisp[p] = 1; mcv[p] = 1; mbusy[p] = 1;
            mchg[p]  = credit_m[p] - price_m[p];
            phase_m[p] = 2;
            mrej[p]  = coins;
         end else if (credit_m[p] > 0 && ccan) begin
            mcv[p] = 1; mbusy[p] = 1;
            mchg[p] = credit_m[p];
            phase_m[p] = 2;
            mrej[p] = coins;
         end else if (coins) begin
            v = c500 ? 500 : 100;
            if (credit_m[p] + v <= 1500) credit_m[p] += v;
            else mrej[p] = 1;
            if (c100 && c500) mrej[p] = 1;
            if (credit_m[p] >= price_m[p]) phase_m[p] = 1;
         end
         mcant[p] = credit_m[p];
      end
   endtask

   task automatic tick();
      logic [27:0] got, exp;
      @(posedge clk);
      model_step({cancel, coin500, coin100});
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         got = (p == 0) ? {cant_a, disp_a, cv_a, chg_a, rej_a, busy_a}
                        : {cant_b, disp_b, cv_b, chg_b, rej_b, busy_b};
         exp = {12'(mcant[p]), mdisp[p], mcv[p], 12'(mchg[p]), mrej[p], mbusy[p]};
         chk((p == 0) ? "cycle_a" : "cycle_b", 32'(got), 32'(exp));
         acc_disp[p] += int'(got[15]);
         acc_cv[p]   += int'(got[14]);
         if (got[14]) acc_chg[p] += int'(got[13:2]);
         acc_rej[p]  += int'(got[1]);
      end
   endtask

   task automatic add(input logic [2:0] btn, input int hold, input int gap, input bit c,
                      input int ca, input int da, input int va, input int ga, input int ra,
                      input int cb, input int db, input int vb, input int gb, input int rb);
      vec_t v;
      v = '{btn, hold, gap, c, ca, da, va, ga, ra, cb, db, vb, gb, rb};
      tbl.push_back(v);
   endtask

   initial begin
      // btn bits: [0] coin100, [1] coin500, [2] cancel
      for (int i = 0; i < 9; i++) add(3'b001, 1, 5, 1, 100*(i+1), 0, 0, 0, 0, 100*(i+1), 0, 0, 0, 0);
      add(3'b001, 1, 5, 1,    0, 1, 1,   0, 0, 1000, 0, 0,    0, 0);
      add(3'b100, 1, 5, 1,    0, 0, 0,   0, 0,    0, 0, 1, 1000, 0);
      add(3'b010, 1, 5, 1,  500, 0, 0,   0, 0,  500, 0, 0,    0, 0);
      add(3'b010, 1, 5, 1,    0, 1, 1,   0, 0, 1000, 0, 0,    0, 0);
      for (int i = 0; i < 4; i++) add(3'b001, 1, 5, 1, 100*(i+1), 0, 0, 0, 0, 1100+100*i, 0, 0, 0, 0);
      add(3'b010, 1, 5, 1,  900, 0, 0,   0, 0, 1400, 0, 0,    0, 1);
      add(3'b001, 1, 5, 1,    0, 1, 1,   0, 0,    0, 1, 1,    0, 0);
      for (int i = 0; i < 3; i++) add(3'b001, 1, 5, 1, 100*(i+1), 0, 0, 0, 0, 100*(i+1), 0, 0, 0, 0);
      add(3'b100, 1, 5, 1,    0, 0, 1, 300, 0,    0, 0, 1,  300, 0);
      add(3'b100, 1, 5, 1,    0, 0, 0,   0, 0,    0, 0, 0,    0, 0);
      add(3'b011, 1, 5, 1,  500, 0, 0,   0, 1,  500, 0, 0,    0, 1);
      add(3'b010, 1, 5, 1,    0, 1, 1,   0, 0, 1000, 0, 0,    0, 0);
      add(3'b010, 50, 5, 1, 500, 0, 0,   0, 0,    0, 1, 1,    0, 0);
      add(3'b010, 1, 5, 1,    0, 1, 1,   0, 0,  500, 0, 0,    0, 0);
      add(3'b010, 1, 5, 1,  500, 0, 0,   0, 0, 1000, 0, 0,    0, 0);
      add(3'b010, 1, 1, 0,    0, 0, 0,   0, 0,    0, 0, 0,    0, 0);
      add(3'b001, 1, 5, 1,    0, 1, 1,   0, 1,    0, 1, 1,    0, 1);
      add(3'b001, 1, 5, 1,  100, 0, 0,   0, 0,  100, 0, 0,    0, 0);
      add(3'b010, 1, 5, 1,  600, 0, 0,   0, 0,  600, 0, 0,    0, 0);
      add(3'b001, 1, 5, 1,  700, 0, 0,   0, 0,  700, 0, 0,    0, 0);
      add(3'b001, 1, 5, 1,  800, 0, 0,   0, 0,  800, 0, 0,    0, 0);

      for (int p = 0; p < 2; p++) begin
         acc_disp[p] = 0; acc_cv[p] = 0; acc_chg[p] = 0; acc_rej[p] = 0;
      end

      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_a", 32'({cant_a, disp_a, cv_a, chg_a, rej_a, busy_a}), 32'd0);
      chk("reset_b", 32'({cant_b, disp_b, cv_b, chg_b, rej_b, busy_b}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         {cancel, coin500, coin100} = tbl[i].btn;
         repeat (tbl[i].hold) tick();
         {cancel, coin500, coin100} = 3'b000;
         repeat (tbl[i].gap) tick();
         if (tbl[i].chk) begin
            chk($sformatf("step%0d_cant_a", i), 32'(cant_a), 32'(tbl[i].ca));
            chk($sformatf("step%0d_disp_a", i), 32'(acc_disp[0]), 32'(tbl[i].da));
            chk($sformatf("step%0d_cv_a", i),   32'(acc_cv[0]),   32'(tbl[i].va));
            chk($sformatf("step%0d_chg_a", i),  32'(acc_chg[0]),  32'(tbl[i].ga));
            chk($sformatf("step%0d_rej_a", i),  32'(acc_rej[0]),  32'(tbl[i].ra));
            chk($sformatf("step%0d_cant_b", i), 32'(cant_b), 32'(tbl[i].cb));
            chk($sformatf("step%0d_disp_b", i), 32'(acc_disp[1]), 32'(tbl[i].db));
            chk($sformatf("step%0d_cv_b", i),   32'(acc_cv[1]),   32'(tbl[i].vb));
            chk($sformatf("step%0d_chg_b", i),  32'(acc_chg[1]),  32'(tbl[i].gb));
            chk($sformatf("step%0d_rej_b", i),  32'(acc_rej[1]),  32'(tbl[i].rb));
            for (int p = 0; p < 2; p++) begin
               acc_disp[p] = 0; acc_cv[p] = 0; acc_chg[p] = 0; acc_rej[p] = 0;
            end
         end
      end

      // Reset between edges with 800 held: outputs clear without waiting for a clock.
      @(posedge clk);
      model_step({cancel, coin500, coin100});
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_a", 32'({cant_a, disp_a, cv_a, chg_a, rej_a, busy_a}), 32'd0);
      chk("midrst_b", 32'({cant_b, disp_b, cv_b, chg_b, rej_b, busy_b}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      coin100 = 1'b1;
      tick();
      coin100 = 1'b0;
      repeat (5) tick();
      chk("after_rst_cant_a", 32'(cant_a), 32'd100);
      chk("after_rst_cant_b", 32'(cant_b), 32'd100);

      for (int r = 0; r < 400; r++) begin
         {cancel, coin500, coin100} = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 3) != 0) cancel = 1'b0;
         repeat ($urandom_range(1, 3)) tick();
         {cancel, coin500, coin100} = 3'b000;
         repeat ($urandom_range(0, 5)) tick();
      end
      repeat (6) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
